// File: rtl/pipeline_pkg.sv
// pipeline_pkg: per-stage payload widths and control bundles for the skid-buffered pipeline registers.
package pipeline_pkg;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic [2:0] alu_ctrl;
        logic       alu_src;
    } idex_ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
    } exmem_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic result_src;
        logic wd3_src;
    } memwb_ctrl_t;

    // IF/ID carries PC, PCPlus4 and the instruction; it has no control bundle of its own yet.
    localparam int IFID_DATA_W  = 96;
    localparam int IFID_CTRL_W  = 1;
    localparam int IDEX_DATA_W  = 32 * 5 + 5 * 3;
    localparam int IDEX_CTRL_W  = $bits(idex_ctrl_t);
    localparam int EXMEM_DATA_W = 32 * 3 + 5;
    localparam int EXMEM_CTRL_W = $bits(exmem_ctrl_t);
    localparam int MEMWB_DATA_W = 32 * 3 + 5;
    localparam int MEMWB_CTRL_W = $bits(memwb_ctrl_t);

    // Encoding is literally {skid_valid, main_valid}; 2'b10 cannot occur.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b11
    } skid_state_e;

endpackage

// File: rtl/pipeline_stage_skid.sv
// pipeline_stage_skid: handshaked pipeline register with a 2-entry skid buffer, stall and flush.
module pipeline_stage_skid
    import pipeline_pkg::*;
#(
    parameter int DATA_W    = MEMWB_DATA_W,
    parameter int CTRL_W    = MEMWB_CTRL_W,
    parameter bit ZERO_CTRL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    logic              main_v_q, main_v_d, skid_v_q, skid_v_d;
    logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
    logic              accept, pop;
    skid_state_e       state;

    assign state     = skid_state_e'({skid_v_q, main_v_q});
    assign in_ready  = ~skid_v_q;
    assign out_valid = main_v_q;
    assign out_data  = main_data_q;
    assign out_ctrl  = (ZERO_CTRL && !main_v_q) ? '0 : main_ctrl_q;
    assign occupancy = {1'b0, main_v_q} + {1'b0, skid_v_q};
    assign accept    = in_valid & ~skid_v_q;
    assign pop       = main_v_q & out_ready;

    always_comb begin
        main_v_d    = main_v_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_v_d    = skid_v_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        if (flush) begin
            main_v_d    = 1'b0;
            skid_v_d    = 1'b0;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        main_v_d    = 1'b1;
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end else if (accept) begin
                        skid_v_d    = 1'b1;
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                    end else if (pop) begin
                        main_v_d = 1'b0;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                        skid_v_d    = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_v_q    <= 1'b0;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_v_q    <= 1'b0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            main_v_q    <= main_v_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_v_q    <= skid_v_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

endmodule

// File: tb/tb_pipeline_stage_skid.sv
// tb_pipeline_stage_skid: directed and randomized checks of the skid pipeline stage against a FIFO scoreboard.
module tb_pipeline_stage_skid;

    localparam int DW = 101;
    localparam int CW = 3;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [DW-1:0] in_data, out_data;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [1:0]    occupancy;

    beat_t         sb[$];
    int            checks = 0;
    int            passes = 0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic [CW-1:0] prev_ctrl;

    always #5 clk = ~clk;

    pipeline_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .ZERO_CTRL(1'b1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .occupancy(occupancy)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic ordy, input logic fl, input logic r);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_state_checks(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_ctrl"}, out_ctrl, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_occupancy"}, occupancy, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
    endtask

    // Reference: the stage is an ordered queue of at most two accepted beats, emptied by flush or reset.
    initial forever begin
        @(negedge clk);
        #1;
        if (rst) begin
            sb.delete();
            prev_stall = 1'b0;
        end else begin
            chk("occupancy", occupancy, sb.size());
            chk("in_ready", in_ready, sb.size() < 2);
            chk("full_and_ready", occupancy == 2'd2 && in_ready, 0);
            chk("out_valid", out_valid, sb.size() > 0);
            if (prev_stall) begin
                chk("stall_data", out_data, prev_data);
                chk("stall_ctrl", out_ctrl, prev_ctrl);
            end
            if (!out_valid) chk("bubble_ctrl", out_ctrl, 0);
            if (out_valid && sb.size() > 0) begin
                chk("head_data", out_data, sb[0].d);
                chk("head_ctrl", out_ctrl, sb[0].c);
                if (out_ready) void'(sb.pop_front());
            end
            if (in_valid && in_ready && !flush) sb.push_back({in_data, in_ctrl});
            if (flush) sb.delete();
            prev_stall = out_valid && !out_ready && !flush;
            prev_data  = out_data;
            prev_ctrl  = out_ctrl;
        end
    end

    initial begin
        int            acc;
        bit            r;
        logic [127:0]  rd;
        logic          v;

        // 1: reset
        cyc(0, '0, '0, 0, 0, 1);
        cyc(0, '0, '0, 0, 0, 1);
        reset_state_checks("s1");

        // 2: streaming at full rate
        for (int i = 0; i < 8; i++) begin
            cyc(1, DW'(i), 3'b101, 1, 0, 0);
            chk("s2_out_valid", out_valid, 1);
            chk("s2_data", out_data, i);
            chk("s2_in_ready", in_ready, 1);
        end
        cyc(0, '0, '0, 1, 0, 0);
        chk("s2_drain", out_valid, 0);

        // 3: back-pressure fills the skid, third beat waits upstream
        cyc(1, DW'('hA), 3'b001, 0, 0, 0);
        cyc(1, DW'('hB), 3'b010, 0, 0, 0);
        chk("s3_occ", occupancy, 2);
        chk("s3_in_ready", in_ready, 0);
        cyc(1, DW'('hC), 3'b011, 0, 0, 0);
        chk("s3_hold_data", out_data, 'hA);
        chk("s3_hold_occ", occupancy, 2);
        acc = 0;
        for (int k = 0; k < 5 && acc == 0; k++) begin
            r = in_ready;
            cyc(1, DW'('hC), 3'b011, 1, 0, 0);
            if (r) acc = 1;
        end
        chk("s3_c_accepted", acc, 1);
        for (int k = 0; k < 3; k++) cyc(0, '0, '0, 1, 0, 0);
        chk("s3_empty", occupancy, 0);

        // 4: flush while full discards everything, including the incoming beat
        cyc(1, DW'('h11), 3'b001, 0, 0, 0);
        cyc(1, DW'('h22), 3'b010, 0, 0, 0);
        chk("s4_occ_full", occupancy, 2);
        cyc(1, DW'('h33), 3'b111, 0, 1, 0);
        chk("s4_occ", occupancy, 0);
        chk("s4_out_valid", out_valid, 0);
        chk("s4_out_ctrl", out_ctrl, 0);
        chk("s4_in_ready", in_ready, 1);
        cyc(0, '0, '0, 1, 0, 0);
        cyc(0, '0, '0, 1, 0, 0);
        chk("s4_no_33", out_valid, 0);

        // 5: reset beats flush while full
        cyc(1, DW'('h44), 3'b101, 0, 0, 0);
        cyc(1, DW'('h55), 3'b110, 0, 0, 0);
        cyc(1, DW'('h66), 3'b111, 0, 1, 1);
        reset_state_checks("s5");

        // 6: random traffic with rare flushes
        acc = 0;
        for (int k = 0; k < 60000 && acc < 10000; k++) begin
            v  = 1'($urandom_range(0, 1));
            rd = {$urandom(), $urandom(), $urandom(), $urandom()};
            r  = in_ready;
            cyc(v, rd[DW-1:0], rd[CW+3:4], 1'($urandom_range(0, 1)), $urandom_range(0, 199) == 0, 0);
            if (v && r && !flush) acc++;
        end
        chk("s6_beats", acc, 10000);
        for (int k = 0; k < 4; k++) cyc(0, '0, '0, 1, 0, 0);
        chk("s6_drained", occupancy, 0);

        @(negedge clk);
        #2;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
